// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//
// Performance-counter bank for the CPU pipeline. Counter 0 counts active
// cycles (plus a single credited cycle on each halt entry); counters
// 1..N_EV count pipeline event strobes. On overflow a counter either wraps to
// zero (SAT=0) or holds all-ones (SAT=1). In both modes it sets a sticky
// overflow flag. A single combinational read mux presents one counter.
//
// Optional feature macro: PERF_SNAPSHOT_EN
//   defined   - shadow registers are built; in_SNAP captures every counter
//               atomically and out_DATA reads the shadow copy.
//   undefined - out_DATA reads the live counter; in_SNAP is ignored.
//
// Parameters:
//   N_EV  - number of event channels (1..15)
//   CNT_W - counter and read-bus width (8..64)
//   SEL_W - read-select width, 2**SEL_W >= N_EV+1
//   SAT   - 0 = wrap on overflow, 1 = saturate at all-ones
//
// Ports:
//   in_CLK    - clock, rising edge
//   in_RST_N  - asynchronous active-low reset
//   in_EN     - pipeline enable (CPU running)
//   in_EV     - event strobes, bit k-1 drives counter k
//   in_CLR    - synchronous clear of counters, flags and halt state
//   in_SNAP   - capture all counters into shadows (level-sampled)
//   in_SEL    - counter index for out_DATA (out of range reads 0)
//   out_DATA  - selected counter value
//   out_OVF   - sticky overflow flag per counter
// -----------------------------------------------------------------------------
module perf_counter_bank #(
  parameter int N_EV  = 4,
  parameter int CNT_W = 32,
  parameter int SEL_W = 4,
  parameter int SAT   = 0
) (
  input  logic             in_CLK,
  input  logic             in_RST_N,
  input  logic             in_EN,
  input  logic [N_EV-1:0]  in_EV,
  input  logic             in_CLR,
  input  logic             in_SNAP,
  input  logic [SEL_W-1:0] in_SEL,
  output logic [CNT_W-1:0] out_DATA,
  output logic [N_EV:0]    out_OVF
);

  localparam int N_CNT = N_EV + 1;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic             inc_cyc;
  logic [N_CNT-1:0] inc;
  logic [CNT_W-1:0] cnt_q [N_CNT];
  logic [N_CNT-1:0] ovf_q;
  logic [CNT_W-1:0] rd_src [N_CNT];

  // Cycle-counter FSM. Entering HALTED still credits the cycle in which
  // in_EN dropped. Once HALTED, counting resumes with the first enabled cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    inc_cyc = 1'b0;
    case (state_q)
      ST_RUN: begin
        inc_cyc = 1'b1;
        if (!in_EN) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (in_EN) begin
          inc_cyc = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign inc = {in_EV, inc_cyc};

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      // NOTE: the counter array is reset element by element. Software reads
      // these values after reset, so they cannot be left to power-up state.
      state_q <= ST_RUN;
      ovf_q   <= '0;
      for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
    end else if (in_CLR) begin
      // Clear wins over any increment requested in the same cycle.
      state_q <= ST_RUN;
      ovf_q   <= '0;
      for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every counter see the pre-edge
      // values, independent of statement order.
      state_q <= state_d;
      for (int i = 0; i < N_CNT; i++) begin
        if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_q[i] <= 1'b1;
            cnt_q[i] <= (SAT != 0) ? CNT_MAX : '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [N_CNT];

  // Shadows take the pre-edge counter values. A snapshot taken together with
  // in_CLR therefore holds the totals from before the clear. in_CLR never
  // touches the shadows.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      for (int i = 0; i < N_CNT; i++) shadow_q[i] <= '0;
    end else if (in_SNAP) begin
      for (int i = 0; i < N_CNT; i++) shadow_q[i] <= cnt_q[i];
    end
  end

  assign rd_src = shadow_q;
`else
  logic unused_snap;
  assign unused_snap = in_SNAP;
  assign rd_src      = cnt_q;
`endif

  // Read mux. An index beyond the last counter reads zero.
  always_comb begin
    out_DATA = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (in_SEL == SEL_W'(i)) out_DATA = rd_src[i];
    end
  end

  assign out_OVF = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_bank
//
// Self-checking bench for perf_counter_bank. Two instances share the same
// stimulus, one wrapping (SAT=0) and one saturating (SAT=1), both with 8-bit
// counters so that overflow is reachable. A reference model in the bench
// keeps counter totals as plain integers. After every edge each read index is
// compared against that model. Directed sequences follow the test plan, and a
// randomized run follows them.
// Build with +define+PERF_SNAPSHOT_EN to exercise the shadow-register variant.
// -----------------------------------------------------------------------------
module tb_perf_counter_bank;

  localparam int N_EV  = 4;
  localparam int CNT_W = 8;
  localparam int SEL_W = 4;
  localparam int N_CNT = N_EV + 1;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [N_EV-1:0]  ev;
  logic             clr;
  logic             snap;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] data_w, data_s;
  logic [N_EV:0]    ovf_w, ovf_s;

  int checks   = 0;
  int failures = 0;

  perf_counter_bank #(.N_EV(N_EV), .CNT_W(CNT_W), .SEL_W(SEL_W), .SAT(0)) u_wrap (
    .in_CLK(clk), .in_RST_N(rst_n), .in_EN(en), .in_EV(ev), .in_CLR(clr),
    .in_SNAP(snap), .in_SEL(sel), .out_DATA(data_w), .out_OVF(ovf_w)
  );

  perf_counter_bank #(.N_EV(N_EV), .CNT_W(CNT_W), .SEL_W(SEL_W), .SAT(1)) u_sat (
    .in_CLK(clk), .in_RST_N(rst_n), .in_EN(en), .in_EV(ev), .in_CLR(clr),
    .in_SNAP(snap), .in_SEL(sel), .out_DATA(data_s), .out_OVF(ovf_s)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: plain integer totals per counter for each overflow mode.
  int          m_cnt_w [N_CNT];
  int          m_cnt_s [N_CNT];
  int          m_sh_w  [N_CNT];
  int          m_sh_s  [N_CNT];
  bit [N_EV:0] m_ovf_w, m_ovf_s;
  bit          m_halted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CNT; i++) begin
      m_cnt_w[i] = 0; m_cnt_s[i] = 0; m_sh_w[i] = 0; m_sh_s[i] = 0;
    end
    m_ovf_w  = '0;
    m_ovf_s  = '0;
    m_halted = 1'b0;
  endtask

  task automatic model_count(input int i);
    if (m_cnt_w[i] == MAXV) m_ovf_w[i] = 1'b1;
    m_cnt_w[i] = (m_cnt_w[i] + 1) % (MAXV + 1);
    if (m_cnt_s[i] == MAXV) m_ovf_s[i] = 1'b1;
    else                    m_cnt_s[i] = m_cnt_s[i] + 1;
  endtask

  // One rising edge in terms of the counting rules.
  task automatic model_edge(input bit e, input bit [N_EV-1:0] v, input bit c, input bit s);
    if (s) begin
      for (int i = 0; i < N_CNT; i++) begin
        m_sh_w[i] = m_cnt_w[i];
        m_sh_s[i] = m_cnt_s[i];
      end
    end
    if (c) begin
      for (int i = 0; i < N_CNT; i++) begin
        m_cnt_w[i] = 0; m_cnt_s[i] = 0;
      end
      m_ovf_w  = '0;
      m_ovf_s  = '0;
      m_halted = 1'b0;
    end else begin
      if (!m_halted) begin
        model_count(0);
        if (!e) m_halted = 1'b1;
      end else if (e) begin
        model_count(0);
        m_halted = 1'b0;
      end
      for (int k = 1; k <= N_EV; k++) if (v[k-1]) model_count(k);
    end
  endtask

  // Sweep every counter index plus two out-of-range indices.
  task automatic check_all();
    int idx [7] = '{0, 1, 2, 3, 4, 5, 15};
    int ew, es;
    foreach (idx[j]) begin
      sel = SEL_W'(idx[j]);
      #1;
      if (idx[j] < N_CNT) begin
`ifdef PERF_SNAPSHOT_EN
        ew = m_sh_w[idx[j]]; es = m_sh_s[idx[j]];
`else
        ew = m_cnt_w[idx[j]]; es = m_cnt_s[idx[j]];
`endif
      end else begin
        ew = 0; es = 0;
      end
      check($sformatf("wrap_sel%0d", idx[j]), 64'(data_w), 64'(ew));
      check($sformatf("sat_sel%0d", idx[j]), 64'(data_s), 64'(es));
    end
    check("wrap_ovf", 64'(ovf_w), 64'(m_ovf_w));
    check("sat_ovf", 64'(ovf_s), 64'(m_ovf_s));
  endtask

  task automatic step(input bit e, input bit [N_EV-1:0] v, input bit c, input bit s);
    en = e; ev = v; clr = c; snap = s;
    @(posedge clk);
    model_edge(e, v, c, s);
    #1;
    check_all();
  endtask

  // Asynchronous reset between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  // Make the current live values readable in the snapshot build as well.
  task automatic capture();
`ifdef PERF_SNAPSHOT_EN
    step(1'b1, '0, 1'b0, 1'b1);
`endif
  endtask

  task automatic read(input int s, output logic [CNT_W-1:0] w, output logic [CNT_W-1:0] t);
    sel = SEL_W'(s);
    #1;
    w = data_w;
    t = data_s;
  endtask

  logic [CNT_W-1:0] rw, rs;

  initial begin
    rst_n = 1'b0; en = 1'b0; ev = '0; clr = 1'b0; snap = 1'b0; sel = '0;
    #3;
    do_reset();

    // Count for a while, then reset asynchronously mid-count.
    for (int i = 0; i < 6; i++) step(1'b1, N_EV'($urandom), 1'b0, 1'b0);
    do_reset();

    // FSM: 5 enabled, 4 disabled, 3 enabled -> 5 + 1 + 3 cycles.
    for (int i = 0; i < 5; i++) step(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 1'b0);
    capture();
    read(0, rw, rs);
    check("fsm_cycles", 64'(rw), 64'd9);
    for (int k = 1; k <= N_EV; k++) begin
      read(k, rw, rs);
      check($sformatf("fsm_ev%0d_zero", k), 64'(rw), 64'd0);
    end

    // Event counting.
    step(1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0100, 1'b0, 1'b0);
    capture();
    read(1, rw, rs); check("ev_cnt1", 64'(rw), 64'd7);
    read(2, rw, rs); check("ev_cnt2", 64'(rw), 64'd7);
    read(3, rw, rs); check("ev_cnt3", 64'(rw), 64'd2);
    read(4, rw, rs); check("ev_cnt4", 64'(rw), 64'd7);
    check("ev_no_ovf", 64'(ovf_w), 64'd0);

    // Wrap overflow: 257 pulses.
    step(1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 257; i++) step(1'b1, 4'b0001, 1'b0, 1'b0);
    capture();
    read(1, rw, rs);
    check("wrap_257", 64'(rw), 64'd1);
    check("sat_257", 64'(rs), 64'd255);
    check("wrap_ovf1", 64'(ovf_w[1]), 64'd1);
    check("sat_ovf1", 64'(ovf_s[1]), 64'd1);
    step(1'b1, '0, 1'b1, 1'b0);
    check("clr_ovf_wrap", 64'(ovf_w), 64'd0);
    check("clr_ovf_sat", 64'(ovf_s), 64'd0);
    capture();
    read(1, rw, rs);
    check("clr_cnt1", 64'(rw), 64'd0);

    // Saturate overflow: 300 pulses.
    step(1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0001, 1'b0, 1'b0);
    capture();
    read(1, rw, rs);
    check("sat_300", 64'(rs), 64'd255);
    check("wrap_300", 64'(rw), 64'd44);
    check("sat_ovf_300", 64'(ovf_s[1]), 64'd1);

    // Snapshot together with clear while events keep arriving.
    step(1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b1, 1'b1);
    read(1, rw, rs);
`ifdef PERF_SNAPSHOT_EN
    check("snap_clr_shadow", 64'(rw), 64'd10);
`else
    check("snap_clr_live", 64'(rw), 64'd0);
`endif
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    read(1, rw, rs);
`ifdef PERF_SNAPSHOT_EN
    check("snap_hold", 64'(rw), 64'd10);
`else
    check("live_restart", 64'(rw), 64'd1);
`endif

    // Select range.
    read(N_EV + 1, rw, rs); check("sel_n_ev_plus1", 64'(rw), 64'd0);
    read(15, rw, rs);       check("sel_max", 64'(rs), 64'd0);

    // Randomized run.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), N_EV'($urandom),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
